// File: rtl/ipg_rreq_engine.sv
// ipg_rreq_engine: read-request engine on the IPG receive path.
// Rebuilds FIRST/MID/LAST read requests from rx_ipg_data, queues them in a job FIFO and
// streams HDR / DATA / END reply chunks out through a valid/ready port.
// Optional feature macro: IPG_RREQ_STATS_EN builds the drop/malform counters; without it both
// stat ports read 0. Parsing and drop behaviour are the same either way.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rx_ipg_data, rreq_valid   incoming block ([7:0] type, [63:8] payload) and its strobe
//   reply_chunk, reply_valid, reply_ready   outgoing reply stream
//   jobq_level, jobq_credit   jobs waiting in the FIFO, and free FIFO slots
//   stat_drop, stat_malform   saturating event counters
module ipg_rreq_engine #(
  parameter int unsigned JOBQ_DEPTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned PORT_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [63:0]                   rx_ipg_data,
  input  logic                          rreq_valid,
  output logic [63:0]                   reply_chunk,
  output logic                          reply_valid,
  input  logic                          reply_ready,
  output logic [$clog2(JOBQ_DEPTH):0]   jobq_level,
  output logic [$clog2(JOBQ_DEPTH):0]   jobq_credit,
  output logic [CNT_WIDTH-1:0]          stat_drop,
  output logic [CNT_WIDTH-1:0]          stat_malform
);

  localparam int unsigned Aw = $clog2(JOBQ_DEPTH);

  localparam logic [7:0] TypeFirst = 8'h2a;
  localparam logic [7:0] TypeMid   = 8'h1a;
  localparam logic [7:0] TypeLast  = 8'h0a;
  localparam logic [7:0] TypeHdr   = 8'h2b;
  localparam logic [7:0] TypeData  = 8'h1b;
  localparam logic [7:0] TypeEnd   = 8'h0b;

  localparam logic [LEN_WIDTH:0] ChunkBits = (LEN_WIDTH+1)'(56);
  localparam logic [Aw:0]        DepthLvl  = (Aw+1)'(JOBQ_DEPTH);

  // The destination address of a request plays no part in the reply, so it is not stored.
  typedef struct packed {
    logic [LEN_WIDTH-1:0]  len;
    logic [PORT_WIDTH-1:0] sport;
    logic [PORT_WIDTH-1:0] dport;
    logic [55:0]           src;
  } job_t;

  logic [7:0]  blk_type;
  logic [55:0] blk_pay;
  assign blk_type = rx_ipg_data[7:0];
  assign blk_pay  = rx_ipg_data[63:8];

  // ---------------------------------------------------------------- parse FSM
  typedef enum logic [1:0] {PIdle, PSrc, PDst} pstate_e;
  pstate_e p_q, p_d;
  logic    cap_hdr, cap_src, push_req;
  job_t    asm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p_q <= PIdle;
    else          p_q <= p_d;
  end

  always_comb begin
    p_d = p_q;
    if (rreq_valid) begin
      unique case (p_q)
        PIdle: if (blk_type == TypeFirst) p_d = PSrc;
        PSrc: begin
          if (blk_type == TypeMid)        p_d = PDst;
          else if (blk_type == TypeFirst) p_d = PSrc;
          else                            p_d = PIdle;
        end
        PDst: begin
          if (blk_type == TypeFirst) p_d = PSrc;
          else                       p_d = PIdle;
        end
        default: p_d = PIdle;
      endcase
    end
  end

  always_comb begin
    // A FIRST block restarts assembly from any state.
    cap_hdr  = rreq_valid && (blk_type == TypeFirst);
    cap_src  = rreq_valid && (p_q == PSrc) && (blk_type == TypeMid);
    push_req = rreq_valid && (p_q == PDst) && (blk_type == TypeLast);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q <= '0;
    end else begin
      if (cap_hdr) begin
        asm_q.len   <= blk_pay[55 -: LEN_WIDTH];
        asm_q.sport <= blk_pay[55-LEN_WIDTH -: PORT_WIDTH];
        asm_q.dport <= blk_pay[55-LEN_WIDTH-PORT_WIDTH -: PORT_WIDTH];
      end
      if (cap_src) asm_q.src <= blk_pay;
    end
  end

  // ---------------------------------------------------------------- job FIFO
  logic [Aw:0] wr_q, rd_q, level;
  logic        full, empty, push_ok, pop;
  job_t        mem_q [JOBQ_DEPTH];

  assign level   = wr_q - rd_q;
  assign full    = (level == DepthLvl);
  assign empty   = (level == '0);
  // Fullness is judged before any same-cycle pop.
  assign push_ok = push_req && !full;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[Aw-1:0]] <= asm_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  assign jobq_level  = level;
  assign jobq_credit = DepthLvl - level;

  // ---------------------------------------------------------------- generator FSM
  typedef enum logic [1:0] {GIdle, GHdr, GData} gstate_e;
  gstate_e          g_q, g_d;
  job_t             job_q;
  logic [LEN_WIDTH:0] rem_q;
  logic             last_chunk;
  logic [55:0]      hdr_pay, end_mask;

  assign last_chunk = (rem_q <= ChunkBits);
  assign end_mask   = ~({56{1'b1}} << rem_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) g_q <= GIdle;
    else          g_q <= g_d;
  end

  always_comb begin
    g_d = g_q;
    unique case (g_q)
      GIdle: if (!empty) g_d = GHdr;
      GHdr:  if (reply_ready) g_d = GData;
      GData: if (reply_ready && last_chunk) g_d = GIdle;
      default: g_d = GIdle;
    endcase
  end

  always_comb begin
    reply_valid = 1'b0;
    reply_chunk = '0;
    pop         = 1'b0;
    hdr_pay     = '0;
    hdr_pay[55 -: LEN_WIDTH]                      = job_q.len;
    hdr_pay[55-LEN_WIDTH -: PORT_WIDTH]           = job_q.dport;
    hdr_pay[55-LEN_WIDTH-PORT_WIDTH -: PORT_WIDTH] = job_q.sport;
    unique case (g_q)
      GIdle: pop = !empty;
      GHdr: begin
        reply_valid = 1'b1;
        reply_chunk = {hdr_pay, TypeHdr};
      end
      GData: begin
        reply_valid = 1'b1;
        if (last_chunk) reply_chunk = {job_q.src & end_mask, TypeEnd};
        else            reply_chunk = {job_q.src, TypeData};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_q <= '0;
      rem_q <= '0;
    end else if (pop) begin
      job_q <= mem_q[rd_q[Aw-1:0]];
      rem_q <= {1'b0, mem_q[rd_q[Aw-1:0]].len};
    end else if ((g_q == GData) && reply_ready && !last_chunk) begin
      rem_q <= rem_q - ChunkBits;
    end
  end

  // ---------------------------------------------------------------- statistics
`ifdef IPG_RREQ_STATS_EN
  logic                 malform_evt, drop_evt;
  logic [CNT_WIDTH-1:0] drop_q, malform_q;

  assign malform_evt = rreq_valid && (((p_q == PSrc) && (blk_type != TypeMid)) ||
                                      ((p_q == PDst) && (blk_type != TypeLast)));
  assign drop_evt    = push_req && full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q    <= '0;
      malform_q <= '0;
    end else begin
      if (drop_evt && (drop_q != '1))       drop_q    <= drop_q + 1'b1;
      if (malform_evt && (malform_q != '1)) malform_q <= malform_q + 1'b1;
    end
  end

  assign stat_drop    = drop_q;
  assign stat_malform = malform_q;
`else
  assign stat_drop    = '0;
  assign stat_malform = '0;
`endif

endmodule
